cfg_bitstream_loader: RTL

//  Writer side of the fabric configuration interface.
//  - Accepts a byte-serial bitstream over a valid/ready handshake and assembles it in a shadow register.
//  - Checks a sync byte and an 8-bit checksum.
//  - On success, commits the image atomically onto the parallel config buses that drive the 3x3 fabric top.
//  - On failure, the previously committed image is held unchanged.

---
 rtl/cfg_bitstream_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cfg_bitstream_loader.sv
// Fabric configuration writer: receives a byte-serial bitstream, assembles it
// in a shadow image, checks sync and checksum, and commits the whole image
// onto the parallel config buses in one edge so the fabric never sees a
// partial configuration.
module cfg_bitstream_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [8:0]   BLE_dff_select,
  output logic [3:0]   IO_sel,
  output logic [19:0]  IO_in,
  output logic [143:0] LUT_in,
  output logic [239:0] SB_in,
  output logic [419:0] CB_in,
  output logic [35:0]  sel_direction_BLEout,
  output logic [17:0]  sel_direction,
  output logic         fabric_hold,
  output logic         cfg_valid,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // Image width actually used; the top 5 bits of the last payload byte are dropped.
  localparam int IMG_W = 891;
  localparam int TW    = $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [6:0]       count;
  logic [7:0]       csum;
  logic [TW-1:0]    tcnt;
  logic             match;
  logic             take;
  logic             in_frame;
  logic             timeout_hit;
  logic [IMG_W-1:0] shadow;
  logic [IMG_W-1:0] cfg_img;

  assign in_ready    = (state != S_COMMIT);
  assign take        = in_valid & in_ready;
  assign in_frame    = (state == S_LOAD) || (state == S_CHECK);
  assign timeout_hit = in_frame && !take && (tcnt == TW'(TIMEOUT - 1));

  // Next-state selection; timeout abort takes priority over frame progress.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (take && (in_data == SYNC_BYTE)) state_nxt = S_LOAD;
      S_LOAD: begin
        if (timeout_hit)                    state_nxt = S_IDLE;
        else if (take && (count == 7'd111)) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (timeout_hit) state_nxt = S_IDLE;
        else if (take)   state_nxt = S_COMMIT;
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, byte counter, running checksum, timeout and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      csum        <= '0;
      tcnt        <= '0;
      match       <= 1'b0;
      fabric_hold <= 1'b0;
      cfg_valid   <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      fabric_hold <= (state_nxt != S_IDLE);
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;

      if (in_frame && !take && !timeout_hit) tcnt <= tcnt + 1'b1;
      else                                   tcnt <= '0;

      if (timeout_hit) cfg_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (take && (in_data == SYNC_BYTE)) begin
            count <= '0;
            csum  <= '0;
          end
        end
        S_LOAD: begin
          if (take) begin
            count <= count + 1'b1;
            csum  <= csum + in_data;
          end
        end
        S_CHECK: begin
          if (take) match <= (in_data == csum);
        end
        S_COMMIT: begin
          if (match) begin
            cfg_done  <= 1'b1;
            cfg_valid <= 1'b1;
          end else begin
            cfg_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow image: cleared on sync, payload byte k lands at bits [8k+7:8k].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if ((state == S_IDLE) && take && (in_data == SYNC_BYTE)) begin
      shadow <= '0;
    end else if ((state == S_LOAD) && take) begin
      for (int i = 0; i < 8; i++) begin
        if ({count, 3'(i)} < 10'(IMG_W)) shadow[{count, 3'(i)}] <= in_data[i];
      end
    end
  end

  // Committed image: replaced in a single edge only when the checksum matched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             cfg_img <= '0;
    else if ((state == S_COMMIT) && match)  cfg_img <= shadow;
  end

  assign BLE_dff_select       = cfg_img[8:0];
  assign IO_sel               = cfg_img[12:9];
  assign IO_in                = cfg_img[32:13];
  assign LUT_in               = cfg_img[176:33];
  assign SB_in                = cfg_img[416:177];
  assign CB_in                = cfg_img[836:417];
  assign sel_direction_BLEout = cfg_img[872:837];
  assign sel_direction        = cfg_img[890:873];

endmodule
